// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - in-order instruction fetch queue between PC and decode
// Tracks outstanding imem requests per slot and drops responses orphaned by a flush.
module ifu_fetch_queue #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [PC_WIDTH-1:0]          pc_in,
    input  logic                         pc_in_valid,
    output logic                         fetch_stall,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic                         imem_rvalid,
    input  logic [INSTR_WIDTH-1:0]       imem_rdata,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTR_WIDTH-1:0]       instr,
    output logic [PC_WIDTH-1:0]          instr_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [OCC_W-1:0]       occ_q, occ_d, discard_cnt_q, discard_cnt_d;
    logic [OCC_W-1:0]       filled_cnt, unfilled_cnt;
    logic [DEPTH-1:0]       filled_q, filled_d;
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic                   do_deq, rsp_fill, rsp_drop, flush_rsp;

    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + OCC_W'(filled_q[i]);
        end
        unfilled_cnt = occ_q - filled_cnt;
    end

    assign fetch_stall = (occ_q == OCC_W'(DEPTH)) | (discard_cnt_q != '0) | flush;
    assign imem_req    = pc_in_valid & ~fetch_stall;
    assign imem_addr   = pc_in;
    assign instr_valid = filled_q[head_q] & (occ_q != '0) & ~flush;
    assign instr       = instr_mem[head_q];
    assign instr_pc    = pc_mem[head_q];
    assign occupancy   = occ_q;

    assign do_deq    = instr_valid & instr_ready;
    assign rsp_drop  = imem_rvalid & (discard_cnt_q != '0);
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fill  = imem_rvalid & (discard_cnt_q == '0) & (unfilled_cnt != '0) & ~flush;
    assign flush_rsp = imem_rvalid & ((discard_cnt_q != '0) | (unfilled_cnt != '0));

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        fill_d        = fill_q;
        occ_d         = occ_q;
        discard_cnt_d = discard_cnt_q;
        filled_d      = filled_q;
        if (flush) begin
            head_d        = '0;
            tail_d        = '0;
            fill_d        = '0;
            occ_d         = '0;
            filled_d      = '0;
            discard_cnt_d = discard_cnt_q + unfilled_cnt - OCC_W'(flush_rsp);
        end else begin
            if (imem_req) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (do_deq) begin
                head_d           = head_q + PTR_W'(1);
                filled_d[head_q] = 1'b0;
            end
            if (rsp_fill) begin
                fill_d           = fill_q + PTR_W'(1);
                filled_d[fill_q] = 1'b1;
            end
            if (rsp_drop) begin
                discard_cnt_d = discard_cnt_q - OCC_W'(1);
            end
            occ_d = occ_q + OCC_W'(imem_req) - OCC_W'(do_deq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            fill_q        <= '0;
            occ_q         <= '0;
            discard_cnt_q <= '0;
            filled_q      <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            fill_q        <= fill_d;
            occ_q         <= occ_d;
            discard_cnt_q <= discard_cnt_d;
            filled_q      <= filled_d;
        end
    end

    // Slot payload needs no reset: the filled bits gate everything that reads it.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            pc_mem[tail_q] <= pc_in;
        end
        if (rsp_fill) begin
            instr_mem[fill_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - self-checking bench for ifu_fetch_queue
// Queue-of-entries reference model plus an in-order memory model with configurable latency.
module tb_ifu_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk, rst_n, flush, pc_in_valid, fetch_stall, imem_req;
    logic        imem_rvalid, instr_valid, instr_ready;
    logic [31:0] pc_in, imem_addr, imem_rdata, instr, instr_pc;
    logic [2:0]  occupancy;

    ifu_fetch_queue #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .pc_in(pc_in), .pc_in_valid(pc_in_valid),
        .fetch_stall(fetch_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] ins; bit filled; } ent_t;
    typedef struct { logic [31:0] data; int due; } rsp_t;

    ent_t        mq[$];
    rsp_t        memq[$];
    logic [31:0] log_pc[$], log_ins[$];
    int          disc = 0, cyc = 0, last_due = 0, mem_lat = 2, n_req = 0;
    bit          mem_rand = 0, mem_hold = 0, exp_req = 0;
    int          n_total = 0, n_pass = 0, n_fail = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a << 5) + 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int  unf, d, lat;
        bit  exp_stall, exp_iv;
        if (!mem_hold && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memq[0].data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        exp_stall = (mq.size() == DEPTH) || (disc != 0) || flush;
        exp_req   = pc_in_valid && !exp_stall;
        exp_iv    = (mq.size() > 0) && mq[0].filled && !flush;
        chk("fetch_stall", fetch_stall, exp_stall);
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, pc_in);
        chk("instr_valid", instr_valid, exp_iv);
        if (exp_iv) begin
            chk("instr", instr, mq[0].ins);
            chk("instr_pc", instr_pc, mq[0].pc);
        end
        chk("occupancy", occupancy, mq.size());
        if (imem_rvalid) chk("rsp_outstanding", (unf > 0 || disc > 0), 1);
        if (imem_req) n_req++;
        if (instr_valid && instr_ready) begin
            log_pc.push_back(instr_pc);
            log_ins.push_back(instr);
        end
        @(posedge clk);
        if (imem_rvalid) void'(memq.pop_front());
        if (flush) begin
            d = disc + unf - (imem_rvalid ? 1 : 0);
            disc = (d < 0) ? 0 : d;
            mq.delete();
        end else begin
            if (imem_rvalid) begin
                if (disc > 0) disc--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].filled = 1;
                            mq[i].ins    = imem_rdata;
                            break;
                        end
                    end
                end
            end
            if (exp_iv && instr_ready) void'(mq.pop_front());
            if (exp_req) begin
                mq.push_back('{pc: pc_in, ins: 32'h0, filled: 0});
                lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                memq.push_back('{data: mem_data(pc_in), due: d});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        pc_in_valid = 0; flush = 0; instr_ready = 1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1; flush = 0; pc_in = 0; pc_in_valid = 0; instr_ready = 0;
        imem_rvalid = 0; imem_rdata = 0;
        #1 rst_n = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_fetch_stall", fetch_stall, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        flush = 1; #1;
        chk("rst_flush_stall", fetch_stall, 1);
        flush = 0;
        @(negedge clk) rst_n = 1;

        // streaming at 2-cycle latency
        mem_lat = 2; instr_ready = 1; log_pc.delete(); log_ins.delete();
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'(i * 4); pc_in_valid = 1; cycle();
        end
        idle(6);
        chk("stream_count", log_pc.size(), 4);
        for (int i = 0; i < 4 && i < log_pc.size(); i++) begin
            chk("stream_pc", log_pc[i], 32'(i * 4));
            chk("stream_ins", log_ins[i], 32'h13 + 32'(i * 32'h80));
        end

        // full back-pressure and stall hold
        mem_lat = 1; instr_ready = 0; n_req = 0;
        for (int i = 0; i < 6; i++) begin
            pc_in = 32'h40 + 32'(i * 4); pc_in_valid = 1; cycle();
        end
        pc_in_valid = 0; #1;
        chk("full_req_count", n_req, 4);
        chk("full_stall", fetch_stall, 1);
        chk("full_occupancy", occupancy, 4);
        for (int i = 0; i < 5; i++) begin
            cycle(); #1;
            chk("hold_pc", instr_pc, 32'h40);
            chk("hold_ins", instr, 32'h813);
            chk("hold_occ", occupancy, 4);
        end
        instr_ready = 1; cycle(); instr_ready = 0; #1;
        chk("deq_occupancy", occupancy, 3);
        chk("deq_stall_drop", fetch_stall, 0);
        idle(6);

        // flush with three requests in flight
        mem_hold = 1; mem_lat = 2;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h100 + 32'(i * 4); pc_in_valid = 1; cycle();
        end
        pc_in_valid = 0; flush = 1; cycle(); flush = 0; #1;
        chk("flush_stall", fetch_stall, 1);
        chk("flush_occ", occupancy, 0);
        mem_hold = 0; log_pc.delete(); log_ins.delete();
        pc_in = 32'h200; pc_in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (exp_req) pc_in = pc_in + 4;
        end
        idle(8);
        chk("flush_first_pc", log_pc.size() > 0 ? log_pc[0] : 32'hx, 32'h200);
        chk("flush_first_ins", log_ins.size() > 0 ? log_ins[0] : 32'hx, 32'h4013);

        // flush coincident with a response
        mem_hold = 1;
        for (int i = 0; i < 2; i++) begin
            pc_in = 32'h280 + 32'(i * 4); pc_in_valid = 1; cycle();
        end
        pc_in_valid = 0; cycle();
        mem_hold = 0; flush = 1; cycle(); flush = 0; #1;
        chk("coinc_stall", fetch_stall, 1);
        cycle(); #1;
        chk("coinc_resume", fetch_stall, 0);
        log_pc.delete(); log_ins.delete();
        pc_in = 32'h300; pc_in_valid = 1; cycle();
        idle(5);
        chk("coinc_pc", log_pc.size() > 0 ? log_pc[0] : 32'hx, 32'h300);
        chk("coinc_ins", log_ins.size() > 0 ? log_ins[0] : 32'hx, 32'h6013);

        // randomized traffic
        mem_rand = 1;
        for (int i = 0; i < 400; i++) begin
            pc_in       = 32'($urandom_range(0, 1023)) << 2;
            pc_in_valid = 1'($urandom_range(0, 3) != 0);
            instr_ready = 1'($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1; pc_in_valid = 0; cycle();
        idle(20);
        mem_rand = 0;

        // asynchronous reset with two filled slots
        mem_lat = 1; instr_ready = 0;
        for (int i = 0; i < 2; i++) begin
            pc_in = 32'h400 + 32'(i * 4); pc_in_valid = 1; cycle();
        end
        pc_in_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        #1;
        chk("pre_rst_valid", instr_valid, 1);
        chk("pre_rst_occ", occupancy, 2);
        #1 rst_n = 0;
        #1;
        chk("async_rst_valid", instr_valid, 0);
        chk("async_rst_occ", occupancy, 0);
        mq.delete(); memq.delete(); disc = 0;
        @(negedge clk) rst_n = 1;
        pc_in = 32'h500; pc_in_valid = 1; instr_ready = 1; cycle();
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
